// File: rtl/audio_capture.sv
// audio_capture: I2S receiver for the WM8731 ADC path.
// Synchronises BCLK/ADCLRCK/ADCDAT into the clk domain, deserialises
// MSB-first left/right words and presents each stereo pair on a
// valid/ready interface with a sticky overrun flag.
// Optional feature macro: AUDIO_CAPTURE_PEAK_EN (adds peak / peak_clr).
module audio_capture #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             bclk,
    input  logic             adc_lr_clk,
    input  logic             adc_dat,
    output logic [WIDTH-1:0] sample_left,
    output logic [WIDTH-1:0] sample_right,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             overrun,
    input  logic             overrun_clr
`ifdef AUDIO_CAPTURE_PEAK_EN
    ,
    input  logic             peak_clr,
    output logic [WIDTH-2:0] peak
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] bclk_sync;
    logic [SYNC_STAGES-1:0] lr_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   bclk_s;
    logic                   lr_s;
    logic                   dat_s;
    logic                   bclk_prev;
    logic                   lr_prev;
    logic                   bclk_rise;
    logic                   lr_edge;

    state_t                 state_q;
    state_t                 state_d;
    logic                   chan_q;
    logic                   chan_d;
    logic [CNT_W-1:0]       bitcnt_q;
    logic [CNT_W-1:0]       bitcnt_d;
    logic [WIDTH-2:0]       shreg_q;
    logic [WIDTH-2:0]       shreg_d;
    logic [WIDTH-1:0]       left_hold_q;
    logic [WIDTH-1:0]       left_hold_d;
    logic                   left_vld_q;
    logic                   left_vld_d;
    logic [WIDTH-1:0]       word_c;
    logic                   pair_c;

    // Multi-stage synchronisers for the three codec inputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bclk_sync <= '0;
            lr_sync   <= '0;
            dat_sync  <= '0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], bclk};
            lr_sync   <= {lr_sync[SYNC_STAGES-2:0], adc_lr_clk};
            dat_sync  <= {dat_sync[SYNC_STAGES-2:0], adc_dat};
        end
    end

    assign bclk_s    = bclk_sync[SYNC_STAGES-1];
    assign lr_s      = lr_sync[SYNC_STAGES-1];
    assign dat_s     = dat_sync[SYNC_STAGES-1];
    assign bclk_rise = bclk_s & ~bclk_prev;
    assign lr_edge   = bclk_rise & (lr_s ^ lr_prev);

    // BCLK edge detector and LRCK history sampled on each BCLK rise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bclk_prev <= 1'b0;
            lr_prev   <= 1'b0;
        end else begin
            bclk_prev <= bclk_s;
            if (bclk_rise) begin
                lr_prev <= lr_s;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and deserialiser control; the edge bit is the I2S delay bit
    always_comb begin
        state_d     = state_q;
        chan_d      = chan_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        left_hold_d = left_hold_q;
        left_vld_d  = left_vld_q;
        pair_c      = 1'b0;
        word_c      = {shreg_q, dat_s};

        if (!enable) begin
            state_d    = ST_IDLE;
            bitcnt_d   = '0;
            left_vld_d = 1'b0;
        end else if (bclk_rise) begin
            case (state_q)
                ST_IDLE: begin
                    if (lr_edge && !lr_s) begin
                        state_d    = ST_SHIFT;
                        chan_d     = 1'b0;
                        bitcnt_d   = '0;
                        left_vld_d = 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (lr_edge) begin
                        // short word: drop it and restart on the new channel
                        chan_d   = lr_s;
                        bitcnt_d = '0;
                        if (!lr_s) begin
                            left_vld_d = 1'b0;
                        end
                    end else begin
                        shreg_d  = word_c[WIDTH-2:0];
                        bitcnt_d = bitcnt_q + CNT_W'(1);
                        if (bitcnt_q == CNT_W'(WIDTH - 1)) begin
                            state_d  = ST_WAIT;
                            bitcnt_d = '0;
                            if (!chan_q) begin
                                left_hold_d = word_c;
                                left_vld_d  = 1'b1;
                            end else begin
                                pair_c     = left_vld_q;
                                left_vld_d = 1'b0;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (lr_edge) begin
                        bitcnt_d = '0;
                        if (!lr_s) begin
                            state_d    = ST_SHIFT;
                            chan_d     = 1'b0;
                            left_vld_d = 1'b0;
                        end else if (left_vld_q) begin
                            state_d = ST_SHIFT;
                            chan_d  = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Deserialiser datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chan_q      <= 1'b0;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            left_hold_q <= '0;
            left_vld_q  <= 1'b0;
        end else begin
            chan_q      <= chan_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            left_hold_q <= left_hold_d;
            left_vld_q  <= left_vld_d;
        end
    end

    // Output pair registers, valid/ready handshake and sticky overrun
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_left  <= '0;
            sample_right <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (pair_c) begin
                sample_left  <= left_hold_q;
                sample_right <= word_c;
                sample_valid <= 1'b1;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
            if (pair_c && sample_valid && !sample_ready) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef AUDIO_CAPTURE_PEAK_EN
    logic [WIDTH-2:0] peak_base_c;
    logic [WIDTH-2:0] peak_next_c;
    logic [WIDTH-2:0] mag_l_c;
    logic [WIDTH-2:0] mag_r_c;

    // Saturating magnitude: the most negative code maps to full scale
    function automatic logic [WIDTH-2:0] mag(input logic [WIDTH-1:0] x);
        if (!x[WIDTH-1]) begin
            mag = x[WIDTH-2:0];
        end else if (x[WIDTH-2:0] == '0) begin
            mag = '1;
        end else begin
            mag = ~x[WIDTH-2:0] + (WIDTH-1)'(1);
        end
    endfunction

    // Peak candidate; a clear in the same cycle as a load zeroes the base
    always_comb begin
        mag_l_c     = mag(left_hold_q);
        mag_r_c     = mag(word_c);
        peak_base_c = peak_clr ? '0 : peak;
        peak_next_c = peak_base_c;
        if (mag_l_c > peak_next_c) begin
            peak_next_c = mag_l_c;
        end
        if (mag_r_c > peak_next_c) begin
            peak_next_c = mag_r_c;
        end
    end

    // Peak register updated on every pair load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            peak <= '0;
        end else if (pair_c) begin
            peak <= peak_next_c;
        end else begin
            peak <= peak_base_c;
        end
    end
`endif

endmodule

// File: tb/tb_audio_capture.sv
// tb_audio_capture: randomized I2S stimulus checked against a slot-level
// model of which stereo pairs the receiver must deliver.
module tb_audio_capture;

    localparam int unsigned WIDTH       = 16;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned BCLK_HALF   = 8;

    logic             clk;
    logic             reset;
    logic             enable;
    logic             bclk;
    logic             adc_lr_clk;
    logic             adc_dat;
    logic [WIDTH-1:0] sample_left;
    logic [WIDTH-1:0] sample_right;
    logic             sample_valid;
    logic             sample_ready;
    logic             overrun;
    logic             overrun_clr;
`ifdef AUDIO_CAPTURE_PEAK_EN
    logic             peak_clr;
    logic [WIDTH-2:0] peak;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [2*WIDTH-1:0] obs_q[$];
    logic [2*WIDTH-1:0] exp_q[$];

    // model state
    logic             m_last_lr = 1'b0;
    logic             m_held_ok = 1'b0;
    logic [WIDTH-1:0] m_held    = '0;
    logic             m_pending = 1'b0;
    logic             m_over    = 1'b0;
    int               m_peak    = 0;

    audio_capture #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .bclk         (bclk),
        .adc_lr_clk   (adc_lr_clk),
        .adc_dat      (adc_dat),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr)
`ifdef AUDIO_CAPTURE_PEAK_EN
        ,
        .peak_clr     (peak_clr),
        .peak         (peak)
`endif
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Record every accepted pair, sampled after inputs settle
    always @(negedge clk) begin
        #1;
        if (!reset && sample_valid && sample_ready) begin
            obs_q.push_back({sample_left, sample_right});
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int mag(input logic [WIDTH-1:0] v);
        int s;
        s = int'($signed(v));
        if (s < 0) s = -s;
        if (s > (2 ** (WIDTH - 1)) - 1) s = (2 ** (WIDTH - 1)) - 1;
        return s;
    endfunction

    // Model: a pair is delivered; handles overwrite under backpressure
    task automatic emit(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
        if (m_pending) begin
            exp_q[exp_q.size() - 1] = {l, r};
            m_over = 1'b1;
        end else begin
            exp_q.push_back({l, r});
        end
        if (!sample_ready) m_pending = 1'b1;
        if (mag(l) > m_peak) m_peak = mag(l);
        if (mag(r) > m_peak) m_peak = mag(r);
    endtask

    task automatic send_bit(input logic lr, input logic d);
        @(negedge clk);
        bclk       = 1'b0;
        adc_lr_clk = lr;
        adc_dat    = d;
        repeat (BCLK_HALF - 1) @(negedge clk);
        @(negedge clk);
        bclk = 1'b1;
        repeat (BCLK_HALF - 1) @(negedge clk);
    endtask

    // One LR slot of nbits BCLKs: delay bit, word MSB first, random filler.
    // drop_at >= 0 lowers enable for three bits starting at that bit.
    task automatic send_slot(input logic ch, input logic [WIDTH-1:0] w, input int nbits, input int drop_at);
        logic lr_edge;
        logic en_word;
        logic en_all;
        logic d;
        lr_edge   = (ch != m_last_lr);
        m_last_lr = ch;
        en_word   = 1'b1;
        en_all    = 1'b1;
        for (int k = 0; k < nbits; k++) begin
            if (k == drop_at) enable = 1'b0;
            if (drop_at >= 0 && k == drop_at + 3) enable = 1'b1;
            if (k >= 1 && k <= int'(WIDTH)) d = w[WIDTH - k];
            else d = 1'($urandom_range(0, 1));
            en_all = en_all & enable;
            if (k <= int'(WIDTH)) en_word = en_word & enable;
            send_bit(ch, d);
        end
        if (drop_at >= 0) enable = 1'b1;
        if (!ch) begin
            m_held_ok = lr_edge && (nbits >= int'(WIDTH) + 1) && en_all;
            m_held    = w;
        end else begin
            if (lr_edge && (nbits >= int'(WIDTH) + 1) && en_word && m_held_ok) emit(m_held, w);
            m_held_ok = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
        send_slot(1'b0, l, 32, -1);
        send_slot(1'b1, r, 32, -1);
    endtask

    task automatic compare_pairs(input string tag);
        int n;
        repeat (4) @(negedge clk);
        #2;
        check_eq({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s_left%0d", tag, i), 32'(obs_q[i][2*WIDTH-1:WIDTH]), 32'(exp_q[i][2*WIDTH-1:WIDTH]));
            check_eq($sformatf("%s_right%0d", tag, i), 32'(obs_q[i][WIDTH-1:0]), 32'(exp_q[i][WIDTH-1:0]));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_left"}, 32'(sample_left), 32'h0);
        check_eq({tag, "_right"}, 32'(sample_right), 32'h0);
        check_eq({tag, "_valid"}, 32'(sample_valid), 32'h0);
        check_eq({tag, "_overrun"}, 32'(overrun), 32'h0);
`ifdef AUDIO_CAPTURE_PEAK_EN
        check_eq({tag, "_peak"}, 32'(peak), 32'h0);
`endif
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        m_last_lr = 1'b0;
        m_held_ok = 1'b0;
        m_pending = 1'b0;
        m_over    = 1'b0;
        m_peak    = 0;
        check_reset_state("midreset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] l;
        logic [WIDTH-1:0] r;
        int ln;
        int rn;

        reset        = 1'b1;
        enable       = 1'b0;
        bclk         = 1'b0;
        adc_lr_clk   = 1'b0;
        adc_dat      = 1'b0;
        sample_ready = 1'b1;
        overrun_clr  = 1'b0;
`ifdef AUDIO_CAPTURE_PEAK_EN
        peak_clr     = 1'b0;
`endif
        repeat (5) @(negedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        reset  = 1'b0;
        enable = 1'b1;

        // prime so the first left slot begins on a real LRCK edge
        send_slot(1'b1, '0, 32, -1);

        // clean stereo capture
        for (int f = 0; f < 4; f++) send_frame(16'h1234, 16'hABCD);
        compare_pairs("clean");
        check_eq("clean_overrun", 32'(overrun), 32'(m_over));
        check_eq("clean_valid_low", 32'(sample_valid), 32'h0);

        // backpressure: two pairs with nobody consuming
        @(negedge clk);
        sample_ready = 1'b0;
        send_frame(16'h0001, 16'h0002);
        send_frame(16'h0003, 16'h0004);
        @(negedge clk);
        #1;
        check_eq("bp_left", 32'(sample_left), 32'h0003);
        check_eq("bp_right", 32'(sample_right), 32'h0004);
        check_eq("bp_valid", 32'(sample_valid), 32'h1);
        check_eq("bp_overrun", 32'(overrun), 32'(m_over));
        @(negedge clk);
        sample_ready = 1'b1;
        m_pending    = 1'b0;
        compare_pairs("bp");
        check_eq("bp_overrun_sticky", 32'(overrun), 32'h1);
        @(negedge clk);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        m_over      = 1'b0;
        #1;
        check_eq("bp_overrun_clr", 32'(overrun), 32'h0);

        // reset mid right slot, enable raised in that slot
        send_slot(1'b0, 16'($urandom), 32, -1);
        send_slot(1'b1, 16'($urandom), 12, -1);
        enable = 1'b0;
        pulse_reset();
        enable = 1'b1;
        send_slot(1'b1, 16'($urandom), 20, -1);
        send_frame(16'h5A5A, 16'hC3C3);
        compare_pairs("midstart");

        // short left word, then a full frame
        send_slot(1'b0, 16'($urandom), 11, -1);
        send_slot(1'b1, 16'($urandom), 32, -1);
        send_frame(16'h7FFF, 16'h8000);
        compare_pairs("short");

        // enable dropped mid left word
        send_slot(1'b0, 16'($urandom), 32, 5);
        send_slot(1'b1, 16'($urandom), 32, -1);
        #1;
        check_eq("endrop_left_held", 32'(sample_left), 32'h7FFF);
        check_eq("endrop_right_held", 32'(sample_right), 32'h8000);
        send_frame(16'h0F0F, 16'hF0F0);
        compare_pairs("endrop");

`ifdef AUDIO_CAPTURE_PEAK_EN
        @(negedge clk);
        peak_clr = 1'b1;
        @(negedge clk);
        peak_clr = 1'b0;
        m_peak   = 0;
        send_frame(16'h0100, 16'hFF00);
        #1;
        check_eq("peak_first", 32'(peak), 32'h0100);
        send_frame(16'h8000, 16'h0010);
        #1;
        check_eq("peak_second", 32'(peak), 32'h7FFF);
        @(negedge clk);
        peak_clr = 1'b1;
        @(negedge clk);
        peak_clr = 1'b0;
        m_peak   = 0;
        #1;
        check_eq("peak_clr", 32'(peak), 32'h0);
        compare_pairs("peak");
`endif

        // random words and occasional short slots
        for (int f = 0; f < 8; f++) begin
            l  = 16'($urandom);
            r  = 16'($urandom);
            ln = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 16)) : 32;
            rn = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 16)) : 32;
            send_slot(1'b0, l, ln, -1);
            send_slot(1'b1, r, rn, -1);
        end
        send_frame(16'($urandom), 16'($urandom));
        compare_pairs("rand");
        check_eq("rand_overrun", 32'(overrun), 32'(m_over));
`ifdef AUDIO_CAPTURE_PEAK_EN
        check_eq("rand_peak", 32'(peak), 32'(m_peak));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/audio_capture.md
Name: audio_capture

Overview:
- I2S receiver for the WM8731 ADC path; the capture-side counterpart of the DAC transmitter.
- Samples AUD_BCLK, AUD_ADCLRCK and AUD_ADCDAT in the CLOCK_50 domain and deserialises MSB-first left/right words.
- Presents each completed stereo pair on a valid/ready interface for downstream logic (loopback, metering, FIFO).
- Codec is bus master for BCLK/LRCK; this block only listens.

Parameters:
- WIDTH, 16, bits per channel word captured; trailing slot bits beyond WIDTH are ignored.
- SYNC_STAGES, 2, flip-flop stages per asynchronous input (bclk, adc_lr_clk, adc_dat); legal range 2..4.

Ports:
- clk  input  1  system clock, CLOCK_50; must be at least 4x bclk frequency.
- reset  input  1  asynchronous, active-high; clears all state.
- enable  input  1  codec configured (audio_ready from codec_cfg); capture runs only while high.
- bclk  input  1  codec bit clock, asynchronous to clk.
- adc_lr_clk  input  1  codec ADC LR clock; 0 = left, 1 = right.
- adc_dat  input  1  codec ADC serial data.
- sample_left  output  WIDTH  last completed left word, two's complement.
- sample_right  output  WIDTH  last completed right word, two's complement.
- sample_valid  output  1  pair available; held until consumed.
- sample_ready  input  1  consumer accepts pair when sample_valid && sample_ready.
- overrun  output  1  sticky: an unconsumed pair was overwritten.
- overrun_clr  input  1  synchronous clear of overrun.

Behaviour:
- Reset: sample_left, sample_right = 0; sample_valid, overrun = 0; FSM = IDLE; shift register, bit counter, synchroniser flops, previous-LRCK flop all 0.
- Synchronisation: each async input passes through SYNC_STAGES flops. bclk_rise = synced bclk is 1 and its previous value was 0. All capture actions occur only in clk cycles where bclk_rise = 1.
- On each bclk_rise, the block samples lr = synced adc_lr_clk and compares it against lr_prev. lr_edge = (lr != lr_prev). lr_prev then updates.
- FSM states:
  - IDLE: wait for enable = 1 and lr_edge with lr = 0 (start of left). The edge bit is the I2S one-bit delay and is discarded. Next state SHIFT; channel = left; bitcnt = 0.
  - SHIFT: on each bclk_rise, shreg = {shreg[WIDTH-2:0], dat}; bitcnt++. When bitcnt reaches WIDTH-1 on a bclk_rise, that rise supplies the LSB:
    - Left channel: latch word into left_hold.
    - Right channel: pair complete.
    - Next state WAIT.
  - WAIT: ignore bits until lr_edge. lr = 1 with the left word held: channel = right, go to SHIFT, bitcnt = 0. lr = 0: channel = left, go to SHIFT.
- lr_edge while in SHIFT (short word): discard the partial word. Restart SHIFT for the channel indicated by lr, with the edge bit again treated as the delay bit. If the new channel is left, left_hold is invalidated.
- Pair completion:
  - sample_left <= left_hold and sample_right <= the assembled right word on the clk cycle after the bclk_rise carrying the right LSB.
  - sample_valid = 1 in that same cycle.
  - Latency: SYNC_STAGES+1 clk after the physical BCLK rising edge.
- Handshake:
  - Consume when sample_valid && sample_ready; sample_valid falls next cycle unless a new pair loads in that same cycle.
  - A new pair arriving while sample_valid = 1 and sample_ready = 0 overwrites the outputs, keeps valid = 1 and sets overrun.
  - A new pair arriving in the same cycle as a consume loads the new pair with valid = 1 and no overrun.
- overrun_clr clears overrun. If overrun_clr and a new overrun event occur in the same cycle, overrun = 1.
- enable falling: FSM -> IDLE on the next clk and any partial word is discarded. Outputs, sample_valid and overrun are held, and the handshake still operates.
- Reset asserted mid-frame: immediate clear. After release the block waits in IDLE for the next left-start edge and never emits a pair made from mixed frames.

Optional Feature:
- Macro: AUDIO_CAPTURE_PEAK_EN.
- Defined:
  - Adds output peak (WIDTH-1 bits) and input peak_clr.
  - On every pair load, peak <= max(peak, |left|, |right|). Magnitude saturates, so |-2^(WIDTH-1)| = 2^(WIDTH-1)-1.
  - peak_clr zeroes peak; a same-cycle load after peak_clr uses 0 as the base.
  - peak resets to 0.
- Undefined: the ports are absent and no extra logic is present.

Test Plan:
- Clean stereo capture: bclk = clk/16, WIDTH = 16, left = 0x1234, right = 0xABCD, 32-bit slots, sample_ready = 1 -> one sample_valid pulse per frame with left = 0x1234 and right = 0xABCD. Repeated over 4 frames with no overrun.
- Backpressure: sample_ready = 0 for 2 frames (0x0001/0x0002, then 0x0003/0x0004) -> outputs show 0x0003/0x0004, valid = 1, overrun = 1. overrun_clr pulse -> overrun = 0.
- Mid-frame start: reset released and enable raised during a right slot -> no output until the next left edge. The first pair equals the next full frame exactly.
- Short word: LR toggles after 10 left bits -> partial word discarded, no sample_valid for that frame. The following full frame 0x7FFF/0x8000 is captured correctly.
- enable dropped mid-left word, then restored -> no pair is emitted from the broken frame. Previously held outputs are unchanged, and capture resumes at the next left edge.
- With AUDIO_CAPTURE_PEAK_EN: pairs 0x0100/0xFF00, then 0x8000/0x0010 -> peak = 0x0100, then 0x7FFF. peak_clr -> peak = 0.
